// File: rtl/ir_decode_sm_pkg.sv
// Shared opcode map and control-path types for the model machine.
// The ALU keys its au_ac selection off the same opcode constants.
package model_pkg;

    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_JG   = 4'b0010;
    localparam logic [3:0] OP_IN   = 4'b0011;
    localparam logic [3:0] OP_OUT  = 4'b0100;
    localparam logic [3:0] OP_MOVI = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MOVD = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_MOVA = 4'b1100;
    localparam logic [3:0] OP_MOVB = 4'b1101;
    localparam logic [3:0] OP_MOVC = 4'b1110;

    localparam logic SM_FETCH = 1'b0;
    localparam logic SM_EXEC  = 1'b1;

    typedef enum logic {
        ST_FETCH = SM_FETCH,
        ST_EXEC  = SM_EXEC
    } sm_state_e;

    typedef struct packed {
        logic mova;
        logic movb;
        logic movc;
        logic movd;
        logic add;
        logic sub;
        logic jmp;
        logic jg;
        logic in1;
        logic out1;
        logic movi;
        logic halt;
    } strobes_t;

endpackage

// File: rtl/ir_decode_sm_if.sv
// Signal bundle between ir_decode_sm and its neighbours (RAM bus, con_signal, ALU).
// The decoder owns the slave side; whoever drives data_in and the enables uses master.
interface ir_decode_sm_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       data_in;
    logic             ir_ld;
    logic             sm_en;
    logic             gf_en;
    logic             alu_gt;

    logic [7:0]       ir;
    logic             sm;
    logic             g;
    logic             mova, movb, movc, movd;
    logic             add, sub, jmp, jg;
    logic             in1, out1, movi, halt;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output data_in, ir_ld, sm_en, gf_en, alu_gt,
        input  ir, sm, g, mova, movb, movc, movd, add, sub, jmp, jg,
               in1, out1, movi, halt, illegal, halted, instr_cnt
    );

    modport slave (
        input  data_in, ir_ld, sm_en, gf_en, alu_gt,
        output ir, sm, g, mova, movb, movc, movd, add, sub, jmp, jg,
               in1, out1, movi, halt, illegal, halted, instr_cnt
    );

endinterface

// File: rtl/ir_decode_sm_op_decoder.sv
// Purely combinational opcode decode; strobes only fire in the execute half-cycle.
module op_decoder
    import model_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       sm_i,
    output strobes_t   strb_o,
    output logic       illegal_o
);

    always_comb begin
        strb_o    = '0;
        illegal_o = 1'b0;
        if (sm_i == SM_EXEC) begin
            case (op_i)
                OP_JMP:  strb_o.jmp  = 1'b1;
                OP_JG:   strb_o.jg   = 1'b1;
                OP_IN:   strb_o.in1  = 1'b1;
                OP_OUT:  strb_o.out1 = 1'b1;
                OP_MOVI: strb_o.movi = 1'b1;
                OP_SUB:  strb_o.sub  = 1'b1;
                OP_MOVD: strb_o.movd = 1'b1;
                OP_HALT: strb_o.halt = 1'b1;
                OP_ADD:  strb_o.add  = 1'b1;
                OP_MOVA: strb_o.mova = 1'b1;
                OP_MOVB: strb_o.movb = 1'b1;
                OP_MOVC: strb_o.movc = 1'b1;
                // 0000, 1010, 1011, 1111 execute as NOPs
                default: illegal_o   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ir_decode_sm.sv
// Instruction register, fetch/execute state bit, greater-than flag and retired count.
// Decode is delegated to op_decoder; every register lives here.
module ir_decode_sm
    import model_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ir_decode_sm_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sm_state_e        state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic             g_q, g_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    strobes_t         strb;
    logic             illegal;

    op_decoder u_op_decoder (
        .op_i      (ir_q[7:4]),
        .sm_i      (state_q == ST_EXEC),
        .strb_o    (strb),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            ir_q     <= 8'h00;
            g_q      <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            g_q      <= g_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        g_d      = g_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        if (bus.sm_en) begin
            state_d = (state_q == ST_FETCH) ? ST_EXEC : ST_FETCH;
        end

        // Once halted, the architectural state is frozen until reset
        if (bus.ir_ld && !halted_q) begin
            ir_d = bus.data_in;
        end
        if (bus.gf_en && !halted_q) begin
            g_d = bus.alu_gt;
        end

        // HALT never retires, even if sm_en is forced high around it
        if ((state_q == ST_EXEC) && bus.sm_en && !halted_q && !strb.halt) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (strb.halt) begin
            halted_d = 1'b1;
        end
    end

    assign bus.ir        = ir_q;
    assign bus.sm        = (state_q == ST_EXEC);
    assign bus.g         = g_q;
    assign bus.halted    = halted_q;
    assign bus.instr_cnt = cnt_q;
    assign bus.illegal   = illegal;

    assign bus.mova      = strb.mova;
    assign bus.movb      = strb.movb;
    assign bus.movc      = strb.movc;
    assign bus.movd      = strb.movd;
    assign bus.add       = strb.add;
    assign bus.sub       = strb.sub;
    assign bus.jmp       = strb.jmp;
    assign bus.jg        = strb.jg;
    assign bus.in1       = strb.in1;
    assign bus.out1      = strb.out1;
    assign bus.movi      = strb.movi;
    assign bus.halt      = strb.halt;

endmodule

// File: tb/tb_ir_decode_sm.sv
// Directed and randomized checks of ir_decode_sm against a cycle-level reference model.
module tb_ir_decode_sm;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ir_decode_sm_if #(.CNT_W(CW)) bus ();

    ir_decode_sm #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference state
    logic [7:0] m_ir;
    logic       m_sm, m_g, m_halted;
    int         m_cnt;

    // Strobe vector bit positions, MSB first: mova movb movc movd add sub jmp jg in1 out1 movi halt
    int op_bit [16] = '{-1, 5, 4, 3, 2, 1, 6, 8, 0, 7, -1, -1, 11, 10, 9, -1};

    logic [11:0] act_strb;
    assign act_strb = {bus.mova, bus.movb, bus.movc, bus.movd, bus.add, bus.sub,
                       bus.jmp, bus.jg, bus.in1, bus.out1, bus.movi, bus.halt};

    function automatic logic [11:0] exp_strb();
        logic [11:0] v = '0;
        if (m_sm && op_bit[m_ir[7:4]] >= 0) v[op_bit[m_ir[7:4]]] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_illegal();
        return m_sm && (op_bit[m_ir[7:4]] < 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ir"},      32'(bus.ir),        32'(m_ir));
        chk({tag, ".sm"},      32'(bus.sm),        32'(m_sm));
        chk({tag, ".g"},       32'(bus.g),         32'(m_g));
        chk({tag, ".halted"},  32'(bus.halted),    32'(m_halted));
        chk({tag, ".cnt"},     32'(bus.instr_cnt), 32'(m_cnt));
        chk({tag, ".strobes"}, 32'(act_strb),      32'(exp_strb()));
        chk({tag, ".illegal"}, 32'(bus.illegal),   32'(exp_illegal()));
    endtask

    task automatic step(input string tag, input logic ld, input logic en, input logic gf,
                        input logic gt, input logic [7:0] din);
        logic halt_now;
        @(negedge clk);
        bus.ir_ld   = ld;
        bus.sm_en   = en;
        bus.gf_en   = gf;
        bus.alu_gt  = gt;
        bus.data_in = din;
        @(posedge clk);
        halt_now = m_sm && (m_ir[7:4] == 4'b1000);
        if (gf && !m_halted) m_g = gt;
        if (m_sm && en && !m_halted && !halt_now) m_cnt = (m_cnt + 1) % (1 << CW);
        if (ld && !m_halted) m_ir = din;
        if (en) m_sm = ~m_sm;
        if (halt_now) m_halted = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.ir_ld   = 1'b0;
        bus.sm_en   = 1'b0;
        bus.gf_en   = 1'b0;
        bus.alu_gt  = 1'b0;
        bus.data_in = 8'h00;
    endtask

    // Pulse reset between edges; outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        m_ir = 8'h00; m_sm = 1'b0; m_g = 1'b0; m_halted = 1'b0; m_cnt = 0;
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        m_ir = 8'h00; m_sm = 1'b0; m_g = 1'b0; m_halted = 1'b0; m_cnt = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of an execute cycle
        step("mid_exec", 1'b1, 1'b1, 1'b0, 1'b0, 8'h9A);
        chk("mid_exec.add", 32'(bus.add), 32'd1);
        do_reset("async_rst");

        // ADD fetch/execute/retire
        step("add_fetch", 1'b1, 1'b1, 1'b0, 1'b0, 8'h96);
        chk("add_only", 32'(act_strb), 32'h080);
        step("add_retire", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("add_cnt", 32'(bus.instr_cnt), 32'd1);

        // Sweep every opcode
        for (int op = 0; op < 16; op++) begin
            step("sweep_fetch", 1'b1, 1'b1, 1'b0, 1'b0, {op[3:0], 4'h3});
            if (op == 8) begin
                step("sweep_halt", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                do_reset("sweep_rst");
            end else begin
                step("sweep_exec", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            end
        end

        // SUB sets g, JG sees it; then with alu_gt=0
        for (int k = 1; k >= 0; k--) begin
            step("sub_fetch", 1'b1, 1'b1, 1'b0, 1'b0, 8'h61);
            step("sub_exec",  1'b0, 1'b1, 1'b1, k[0], 8'h00);
            step("jg_fetch",  1'b1, 1'b1, 1'b0, 1'b0, 8'h27);
            chk("jg_sees_g", 32'(bus.g), 32'(k));
            step("jg_exec",   1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        step("sub_fetch", 1'b1, 1'b1, 1'b0, 1'b0, 8'h62);
        step("sub_exec",  1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) step("g_hold", 1'b0, 1'b1, 1'b0, i[0], 8'h00);
        chk("g_held", 32'(bus.g), 32'd1);

        // HALT freezes sm, ir, g and count despite ir_ld pulses
        step("halt_fetch", 1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 20; i++)
            step("halted", i[0], 1'b0, i[1], 1'b1, 8'($urandom));
        chk("halt_sm", 32'(bus.sm), 32'd1);
        chk("halt_flag", 32'(bus.halted), 32'd1);
        do_reset("halt_rst");

        // 17 retired instructions wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            step("wrap_fetch", 1'b1, 1'b1, 1'b0, 1'b0, 8'h9F);
            step("wrap_exec",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("wrap_cnt", 32'(bus.instr_cnt), 32'd1);

        // Randomized program stream
        for (int i = 0; i < 400; i++) begin
            logic ld, en, gf;
            if (m_halted && ($urandom % 4 == 0)) do_reset("rand_rst");
            ld = m_sm ? ($urandom % 8 == 0) : ($urandom % 8 != 0);
            en = (m_sm && m_ir[7:4] == 4'b1000) ? ($urandom % 8 == 0) : ($urandom % 8 != 0);
            gf = (m_sm && m_ir[7:4] == 4'b0110) || ($urandom % 16 == 0);
            step("rand", ld, en, gf, 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ir_decode_sm.md
Name: ir_decode_sm

Overview:
- Front end of the model machine's control path.
- Holds the instruction register and the fetch/execute state bit `sm`. Decodes `ir[7:4]` into the one-hot instruction strobes consumed by `con_signal`, and holds the greater-than flag `g`.
- Drives: `mova`, `movb`, `movc`, `movd`, `add`, `sub`, `jmp`, `jg`, `in1`, `out1`, `movi`, `halt`, `sm`, `g`, `ir`.
- Consumes back from `con_signal`: `ir_ld`, `sm_en`, `gf_en`.

Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_in`  in  8  RAM read-data bus.
- `ir_ld`  in  1  load IR from `data_in`, from `con_signal`.
- `sm_en`  in  1  state-bit advance enable, from `con_signal` (deasserted by `halt`).
- `gf_en`  in  1  flag load enable, from `con_signal`.
- `alu_gt`  in  1  ALU greater-than result.
- `ir`  out  8  instruction register.
- `sm`  out  1  0 = fetch, 1 = execute.
- `g`  out  1  registered greater-than flag.
- `mova`, `movb`, `movc`, `movd`, `add`, `sub`, `jmp`, `jg`, `in1`, `out1`, `movi`, `halt`  out  1 each  one-hot instruction strobes.
- `illegal`  out  1  unassigned opcode in execute.
- `halted`  out  1  sticky halt indicator.
- `instr_cnt`  out  `CNT_W`  retired-instruction count.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: `ir`=8'h00, `sm`=0, `g`=0, `halted`=0, `instr_cnt`=0. All strobes and `illegal` read 0 during and after reset because `sm`=0.
- Reset mid-instruction: returns to fetch immediately. No partial IR is kept.
- State bit `sm`:
  - If `sm_en`=1: `sm` toggles every clk, giving fetch(0) -> execute(1) -> fetch.
  - If `sm_en`=0: `sm` holds.
- IR load:
  - On a clk edge with `ir_ld`=1, `ir` <= `data_in`. Otherwise `ir` holds.
  - `ir_ld` is active only in fetch, so the new IR and `sm`=1 appear on the same edge.
  - Strobes are valid for the whole execute cycle, with zero extra latency.
- Decode: combinational from `ir[7:4]`, gated by `sm`=1. All strobes are 0 in fetch. Opcode map:
  - 0001 `jmp`
  - 0010 `jg`
  - 0011 `in1`
  - 0100 `out1`
  - 0101 `movi`
  - 0110 `sub`
  - 0111 `movd`
  - 1000 `halt`
  - 1001 `add`
  - 1100 `mova`
  - 1101 `movb`
  - 1110 `movc`
- Unassigned opcodes (0000, 1010, 1011, 1111) behave as NOP: no strobe, `illegal`=1 during execute, and the machine continues.
- Exactly one strobe (or `illegal`) is high in every execute cycle.
- Halt:
  - `halt`=1 makes `con_signal` drop `sm_en`, so `sm` freezes at 1 and `halt` stays asserted.
  - `halted` is set on the first clk edge where `halt`=1. It stays set until `rst_n`.
  - While `halted`=1, `ir`, `g` and `instr_cnt` hold, and `ir_ld` is ignored.
- Flag `g`:
  - On a clk edge with `gf_en`=1, `g` <= `alu_gt`. Otherwise `g` holds.
  - `g` is updated at the end of the SUB execute cycle and is visible to any later JG.
  - A JG immediately following a SUB sees the new `g`.
- Counter:
  - `instr_cnt` increments on each edge where `sm`=1, `sm_en`=1 and `halted`=0 (execute completing).
  - Wraps modulo 2^`CNT_W`, with no saturation.
  - The HALT instruction itself is not counted.
- Simultaneous `gf_en` and `halt`: cannot occur under the decode map. The flag update has priority if driven externally.

Decomposition:
- Shared package `model_pkg`:
  - 4-bit opcode constants: `OP_JMP`, `OP_JG`, `OP_IN`, `OP_OUT`, `OP_MOVI`, `OP_SUB`, `OP_MOVD`, `OP_HALT`, `OP_ADD`, `OP_MOVA`, `OP_MOVB`, `OP_MOVC`.
  - `SM_FETCH`=0, `SM_EXEC`=1.
- The ALU uses the same `model_pkg` opcode constants for `au_ac`.
- One natural sub-module, `op_decoder`: purely combinational opcode/`sm` -> strobes + `illegal`. The registers stay in `ir_decode_sm`.

Test Plan:
- Reset: `rst_n` low mid-execute with `ir`=8'h9A -> `ir`=00, `sm`=0, all strobes 0, `instr_cnt`=0, asynchronously (before next clk).
- Fetch/decode: `sm_en`=1, `ir_ld`=~`sm`, `data_in`=8'h96 at fetch -> next cycle `ir`=96, `sm`=1, `add`=1 only; following cycle `sm`=0, `add`=0, `instr_cnt`=1.
- Full opcode sweep: all 16 values of `data_in[7:4]` -> matching single strobe per the map. 0000/1010/1011/1111 give `illegal`=1 and no strobe.
- Flag: SUB with `gf_en`=1 and `alu_gt`=1, then JG -> `g`=1 during JG execute. A repeat with `alu_gt`=0 gives `g`=0. `gf_en`=0 with `alu_gt` toggling leaves `g` unchanged.
- Halt: `data_in`=8'h80, `sm_en` driven ~`halt` -> `sm` stuck at 1, `halt`=1, `halted`=1. `ir`/`instr_cnt` are unchanged over 20 cycles despite `ir_ld` pulses. `rst_n` pulse clears.
- Counter wrap: `CNT_W`=4, 17 executes -> `instr_cnt` reads 1.
